// File: rtl/data_mem_256x8.sv
// Single-port data memory for the load/store unit: synchronous write, combinational read.
// The storage array is deliberately named my_memory so benches can preload/inspect it.
module data_mem_256x8 #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          reset_i,
    input  logic [AW-1:0] DataAddress,
    input  logic          ReadMem,
    input  logic          WriteMem,
    input  logic [DW-1:0] DataIn,
    output logic [DW-1:0] DataOut
);

    logic [DW-1:0] my_memory [0:2**AW-1];

    logic wr_en;

    // Reset only blocks writes; the array itself is never cleared so preloaded operands survive.
    always_comb begin
        wr_en = WriteMem && !reset_i;
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            my_memory[DataAddress] <= DataIn;
        end
    end

    // No write-data bypass: a same-address write shows up only after the edge.
    always_comb begin
        DataOut = '0;
        if (ReadMem) begin
            DataOut = my_memory[DataAddress];
        end
    end

endmodule

// File: tb/tb_data_mem_256x8.sv
// Self-checking bench for data_mem_256x8: directed memory-map cases plus a random write/readback pass.
module tb_data_mem_256x8;

    logic       clk;
    logic       rst_i;
    logic [7:0] addr;
    logic       rd;
    logic       we;
    logic [7:0] din;
    logic [7:0] dout;

    int vec_cnt;
    int err_cnt;

    logic [7:0] exp_q[$];
    logic [7:0] model_mem [0:255];
    logic [7:0] wr_list[$];

    data_mem_256x8 #(.AW(8), .DW(8)) dut (
        .CLK         (clk),
        .reset_i     (rst_i),
        .DataAddress (addr),
        .ReadMem     (rd),
        .WriteMem    (we),
        .DataIn      (din),
        .DataOut     (dout)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it to what the DUT shows now.
    task automatic sb_compare(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL %s: observed %h expected <empty queue>", tag, dout);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, dout, e);
        end
    endtask

    // Inputs change on the falling edge; comparisons happen 1 time unit later.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic under_rst);
        @(negedge clk);
        addr  = a;
        din   = d;
        we    = 1'b1;
        rd    = 1'b0;
        rst_i = under_rst;
        @(posedge clk);
        #1;
        we    = 1'b0;
        rst_i = 1'b0;
        if (!under_rst) begin
            model_mem[a] = d;
        end
    endtask

    task automatic do_read(input logic [7:0] a, input string tag);
        @(negedge clk);
        addr = a;
        rd   = 1'b1;
        we   = 1'b0;
        exp_q.push_back(model_mem[a]);
        #1;
        sb_compare(tag);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] d;
        vec_cnt = 0;
        err_cnt = 0;
        rst_i   = 1'b1;
        we      = 1'b0;
        rd      = 1'b0;
        addr    = '0;
        din     = '0;

        // 1. Hierarchical preload during reset; reads stay live under reset.
        #1;
        dut.my_memory[64] = 8'h3C;
        dut.my_memory[65] = 8'h00;
        model_mem[64] = 8'h3C;
        model_mem[65] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rd = 1'b1;
        addr = 8'd64;
        exp_q.push_back(8'h3C);
        #1;
        sb_compare("rst_rd64");
        addr = 8'd65;
        exp_q.push_back(8'h00);
        #1;
        sb_compare("rst_rd65");
        @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        do_read(8'd64, "post_rst_rd64");
        do_read(8'd65, "post_rst_rd65");
        check_val("arr64", dut.my_memory[64], 8'h3C);

        // 2. Plain write then read at the integer-result MSB.
        do_write(8'd66, 8'hA5, 1'b0);
        do_read(8'd66, "wr_rd66");
        check_val("arr66", dut.my_memory[66], 8'hA5);

        // 3. Establish a prior value, then a write under reset must not land.
        do_write(8'd67, 8'h77, 1'b0);
        do_write(8'd67, 8'h5A, 1'b1);
        do_read(8'd67, "rst_blocks_wr67");
        check_val("arr67", dut.my_memory[67], 8'h77);

        // 4. ReadMem low forces zero regardless of address.
        foreach (model_mem[i]) begin end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd   = 1'b0;
            addr = (i == 0) ? 8'd64 : (i == 1) ? 8'd66 : (i == 2) ? 8'd67 : 8'd65;
            exp_q.push_back(8'h00);
            #1;
            sb_compare($sformatf("rd_gate_%0d", i));
        end

        // 5. Address boundaries, no aliasing between 0 and 255.
        do_write(8'd0,   8'h01, 1'b0);
        do_write(8'd255, 8'hFF, 1'b0);
        do_read(8'd0,   "edge_rd0");
        do_read(8'd255, "edge_rd255");

        // 6. Same-cycle read and write: old data before the edge, new data after.
        do_write(8'd12, 8'h11, 1'b0);
        @(negedge clk);
        addr = 8'd12;
        din  = 8'h22;
        rd   = 1'b1;
        we   = 1'b1;
        exp_q.push_back(8'h11);
        #1;
        sb_compare("rdw_before");
        model_mem[12] = 8'h22;
        exp_q.push_back(8'h22);
        @(posedge clk);
        #1;
        we = 1'b0;
        sb_compare("rdw_after");

        // Random writes followed by readback of every address touched.
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            do_write(a, d, 1'b0);
            wr_list.push_back(a);
        end
        for (int i = 0; i < wr_list.size(); i++) begin
            do_read(wr_list[i], $sformatf("rand_rd_%0d_a%0d", i, wr_list[i]));
        end

        // Re-read the preloaded operand unless the random pass overwrote it.
        if (model_mem[64] === 8'h3C) begin
            do_read(8'd64, "final_rd64");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
